crc_sram_sequencer: RTL and testbench

CRC_SRAM_SEQUENCER -- requirements
Module: crc_sram_sequencer

---
 rtl/crc_sram_sequencer_pkg.sv | 18 +
 rtl/crc_sram_sequencer_crc32.sv | 20 ++
 rtl/crc_sram_sequencer.sv | 119 +++++++++++
 tb/tb_crc_sram_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/crc_sram_sequencer_pkg.sv
// Shared constants and state encoding for the CRC-over-SRAM sequencer.
package crc_sram_sequencer_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 10;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned SRAM_DEPTH     = 1024;

    // Reflected CRC-32 polynomial (IEEE 802.3, LSB-first form)
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/crc_sram_sequencer_crc32.sv
// Combinational CRC-32 update of one 32-bit word, LSB-first, no final inversion.
module crc_sram_sequencer_crc32
    import crc_sram_sequencer_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [31:0] init,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = init ^ data_in;
        for (int i = 0; i < 32; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_sram_sequencer.sv
// Reads N consecutive SRAM words starting at base_addr and folds them into a CRC-32.
module crc_sram_sequencer
    import crc_sram_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [DATA_WIDTH-1:0] init,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] crc_result,
    output logic                  csb0,
    output logic                  web0,
    output logic [3:0]            wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] acc, acc_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  csb_next;
    logic                  busy_next;
    logic                  done_next;
    logic [DATA_WIDTH-1:0] result_next;
    logic                  rv;
    logic [DATA_WIDTH-1:0] crc_out;

    // The array is only ever read.
    assign web0   = 1'b1;
    assign wmask0 = 4'b0000;

    crc_sram_sequencer_crc32 u_crc32 (
        .data_in (dout0),
        .init    (acc),
        .crc_out (crc_out)
    );

    always_comb begin
        state_next  = state;
        acc_next    = rv ? crc_out : acc;
        cnt_next    = cnt;
        addr_next   = addr0;
        csb_next    = 1'b1;
        busy_next   = 1'b0;
        done_next   = 1'b0;
        result_next = crc_result;

        case (state)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (start) begin
                    if (num_words == '0) begin
                        state_next  = ST_DONE;
                        done_next   = 1'b1;
                        result_next = init;
                    end else begin
                        state_next = ST_RUN;
                        acc_next   = init;
                        cnt_next   = num_words;
                        addr_next  = base_addr;
                        csb_next   = 1'b0;
                        busy_next  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                busy_next = 1'b1;
                // cnt counts issues still owed including the one in flight this cycle
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_DRAIN;
                end else begin
                    csb_next  = 1'b0;
                    addr_next = addr0 + ADDR_WIDTH'(1);
                    cnt_next  = cnt - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                state_next  = ST_DONE;
                done_next   = 1'b1;
                result_next = crc_out;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state      <= ST_IDLE;
            acc        <= '0;
            cnt        <= '0;
            addr0      <= '0;
            csb0       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            crc_result <= '0;
            rv         <= 1'b0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            cnt        <= cnt_next;
            addr0      <= addr_next;
            csb0       <= csb_next;
            busy       <= busy_next;
            done       <= done_next;
            crc_result <= result_next;
            rv         <= ~csb0;
        end
    end

endmodule

// File: tb/tb_crc_sram_sequencer.sv
// Self-checking bench: SRAM model plus byte-table CRC-32 reference over the preloaded array.
module tb_crc_sram_sequencer;

    localparam int AW = 10;
    localparam int DEPTH = 1024;

    logic          clk0;
    logic          rst0;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic [31:0]   init;
    logic          busy;
    logic          done;
    logic [31:0]   crc_result;
    logic          csb0;
    logic          web0;
    logic [3:0]    wmask0;
    logic [AW-1:0] addr0;
    logic [31:0]   dout0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [DEPTH];
    logic [31:0] tab [256];

    typedef struct {
        logic [AW-1:0] base;
        int            num;
        logic [31:0]   seed;
        int            exp_done;
        int            exp_busy;
    } vec_t;

    vec_t vecs [6];

    crc_sram_sequencer dut (
        .clk0       (clk0),
        .rst0       (rst0),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .init       (init),
        .busy       (busy),
        .done       (done),
        .crc_result (crc_result),
        .csb0       (csb0),
        .web0       (web0),
        .wmask0     (wmask0),
        .addr0      (addr0),
        .dout0      (dout0)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // Synchronous-read SRAM; garbage on the data bus whenever no read was issued
    always @(posedge clk0) begin
        if (csb0 === 1'b0) dout0 <= mem[addr0];
        else               dout0 <= $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_crc(input logic [AW-1:0] b, input int n, input logic [31:0] seed);
        logic [31:0] c;
        logic [31:0] w;
        c = seed;
        for (int k = 0; k < n; k++) begin
            w = mem[(int'(b) + k) % DEPTH];
            for (int by = 0; by < 4; by++)
                c = (c >> 8) ^ tab[8'(c ^ (w >> (8 * by)))];
        end
        return c;
    endfunction

    // Caller must be mid-cycle; returns #1 after the edge that opened the done cycle.
    task automatic run_pass(input logic [AW-1:0] b, input int n, input logic [31:0] seed,
                            input int exp_done, input int exp_busy, input int glitch);
        logic [31:0] exp;
        int  issued, busy_cnt, done_cyc;
        bit  bus_ok;
        exp = model_crc(b, n, seed);
        base_addr = b;
        num_words = 11'(n);
        init      = seed;
        start     = 1'b1;
        @(posedge clk0); #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        num_words = 11'($urandom);
        init      = $urandom;
        issued = 0; busy_cnt = 0; done_cyc = -1; bus_ok = 1'b1;
        for (int c = 1; c <= 1200; c++) begin
            if (web0 !== 1'b1 || wmask0 !== 4'b0) bus_ok = 1'b0;
            if (csb0 === 1'b0) begin
                if (c > n || addr0 !== AW'(int'(b) + issued)) bus_ok = 1'b0;
                issued++;
            end else if (csb0 !== 1'b1) bus_ok = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            start = (c == glitch);
            if (c == glitch) begin
                base_addr = AW'($urandom);
                num_words = 11'($urandom_range(1, 5));
            end
            @(posedge clk0); #1;
        end
        start = 1'b0;
        chk("read_count", 32'(issued), 32'(n));
        chk("addr_sequence", 32'(bus_ok), 32'd1);
        chk("done_cycle", 32'(done_cyc), 32'(exp_done));
        chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        chk("crc_result", crc_result, exp);
    endtask

    task automatic idle_pass(input logic [AW-1:0] b, input int n, input logic [31:0] seed);
        @(posedge clk0); #1;
        run_pass(b, n, seed, (n == 0) ? 1 : n + 2, (n == 0) ? 0 : n + 1, 0);
        @(posedge clk0); #1;
        chk("done_single_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        bit bad;
        logic [31:0] r;
        rst0 = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; init = '0;

        for (int i = 0; i < 256; i++) begin
            r = 32'(i);
            for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
            tab[i] = r;
        end
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333; mem[3] = 32'h4444_4444;

        vecs[0] = '{10'd0,    4,    32'hFFFF_FFFF, 6,    5};
        vecs[1] = '{10'd1022, 4,    32'h1234_5678, 6,    5};
        vecs[2] = '{10'd0,    0,    32'hDEAD_BEEF, 1,    0};
        vecs[3] = '{10'd0,    1024, 32'hFFFF_FFFF, 1026, 1025};
        vecs[4] = '{10'd1023, 1,    32'h0000_0000, 3,    2};
        vecs[5] = '{10'd7,    3,    32'hA5A5_5A5A, 5,    4};

        repeat (3) @(posedge clk0);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_crc_result", crc_result, 32'd0);
        chk("rst_csb0", 32'(csb0), 32'd1);
        chk("rst_addr0", 32'(addr0), 32'd0);
        chk("rst_web0", 32'(web0), 32'd1);
        chk("rst_wmask0", 32'(wmask0), 32'd0);
        rst0 = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(posedge clk0); #1;
            run_pass(vecs[i].base, vecs[i].num, vecs[i].seed, vecs[i].exp_done, vecs[i].exp_busy, 0);
            @(posedge clk0); #1;
            chk("done_single_pulse", 32'(done), 32'd0);
        end

        // Start pulsed mid-pass is ignored; start held in the done cycle chains immediately
        @(posedge clk0); #1;
        run_pass(10'd200, 10, $urandom, 12, 11, 3);
        run_pass(10'd300, 5, $urandom, 7, 6, 0);
        run_pass(10'd900, 0, 32'hCAFE_F00D, 1, 0, 0);
        @(posedge clk0); #1;
        chk("chain_done_single_pulse", 32'(done), 32'd0);

        // Reset in cycle 3 of an N=8 pass aborts it silently
        @(posedge clk0); #1;
        base_addr = 10'd100; num_words = 11'd8; init = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk0); #1;
        start = 1'b0;
        @(posedge clk0); #1;
        @(posedge clk0); #1;
        rst0 = 1'b1;
        @(posedge clk0); #1;
        rst0 = 1'b0;
        chk("abort_csb0", 32'(csb0), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_crc_result", crc_result, 32'd0);
        bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done !== 1'b0 || csb0 !== 1'b1 || busy !== 1'b0) bad = 1'b1;
            @(posedge clk0); #1;
        end
        chk("abort_quiet", 32'(bad), 32'd0);
        idle_pass(10'd50, 2, 32'h0BAD_CAFE);

        for (int t = 0; t < 25; t++) begin
            int n;
            n = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40);
            if ($urandom_range(0, 1) == 1)
                idle_pass(AW'($urandom), n, $urandom);
            else
                run_pass(AW'($urandom), n, $urandom, (n == 0) ? 1 : n + 2, (n == 0) ? 0 : n + 1, 0);
        end
        @(posedge clk0); #1;
        chk("final_done_low", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
